// File: rtl/nn_pkg.sv
// -----------------------------------------------------------------------------
// nn_pkg
// Shared definitions for the neural-network datapath blocks.
//   state_e   : IDLE / ACCUM / DONE encodings used by the multiplier FSMs
//   clog2     : ceiling log2 for sizing index registers
//   saturate  : clamp a signed value into a signed range of the given width
// No ports (package).
// -----------------------------------------------------------------------------
package nn_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Clamp value into [-2^(width-1), 2^(width-1)-1].
  function automatic logic signed [63:0] saturate(input logic signed [63:0] value,
                                                  input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/mvm_transpose_mac_lane.sv
// -----------------------------------------------------------------------------
// mac_lane
// Signed multiply-accumulate lane: acc += a * b when enabled, synchronous
// clear has priority over enable. One lane per output element.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   clr_i      : synchronous clear of the accumulator
//   en_i       : accumulate enable
//   a_i, b_i   : signed WIDTH-bit operands
//   acc_o      : signed ACC_WIDTH-bit running sum
// -----------------------------------------------------------------------------
module mac_lane #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 19
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clr_i,
  input  logic                        en_i,
  input  logic signed [WIDTH-1:0]     a_i,
  input  logic signed [WIDTH-1:0]     b_i,
  output logic signed [ACC_WIDTH-1:0] acc_o
);

  logic signed [2*WIDTH-1:0]   prod;
  logic signed [ACC_WIDTH-1:0] acc_q;
  logic signed [ACC_WIDTH-1:0] acc_d;

  assign prod = a_i * b_i;

  always_comb begin
    acc_d = acc_q;
    if (clr_i)     acc_d = '0;
    else if (en_i) acc_d = acc_q + ACC_WIDTH'(prod);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/mvm_transpose.sv
// -----------------------------------------------------------------------------
// mvm_transpose
// Backward-pass transposed matrix-vector multiplier: y = W^T * e.
// W is MATRIX_ROWS x SHARED_DIM in the forward layer's packed layout, e has
// MATRIX_ROWS elements, y has SHARED_DIM elements. One row of W is consumed
// per cycle, all SHARED_DIM columns in parallel (one mac_lane each).
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   start         : request, sampled only in IDLE
//   matrix        : W[r][c] at [WIDTH*SHARED_DIM*(MATRIX_ROWS-r)-WIDTH*c-1 -: WIDTH]
//   vector        : e[r] at [WIDTH*(MATRIX_ROWS-r)-1 -: WIDTH]
//   result_vector : y[c] at [ACC_WIDTH*(SHARED_DIM-c)-1 -: ACC_WIDTH]
//   busy          : high from the start-sampling edge through the done cycle
//   done          : one-cycle completion pulse
// Build option: define MVM_TRANSPOSE_SAT_EN to clamp each y[c] to the signed
// WIDTH range (sign-extended back to ACC_WIDTH); otherwise full precision.
// -----------------------------------------------------------------------------
module mvm_transpose
  import nn_pkg::*;
#(
  parameter int MATRIX_ROWS = 6,
  parameter int SHARED_DIM  = 3,
  parameter int WIDTH       = 8,
  parameter int ACC_WIDTH   = 19
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [MATRIX_ROWS*SHARED_DIM*WIDTH-1:0] matrix,
  input  logic [MATRIX_ROWS*WIDTH-1:0]          vector,
  output logic [SHARED_DIM*ACC_WIDTH-1:0]       result_vector,
  output logic                                  busy,
  output logic                                  done
);

  localparam int RIDX_W = (clog2(MATRIX_ROWS) < 1) ? 1 : clog2(MATRIX_ROWS);
  localparam logic [RIDX_W-1:0] LAST_ROW = RIDX_W'(MATRIX_ROWS - 1);

  state_e                                state_q;
  logic [RIDX_W-1:0]                     row_idx_q;
  logic [MATRIX_ROWS*SHARED_DIM*WIDTH-1:0] matrix_q;
  logic [MATRIX_ROWS*WIDTH-1:0]          vector_q;
  logic [SHARED_DIM*ACC_WIDTH-1:0]       result_q;
  logic                                  busy_q;
  logic                                  done_q;

  logic signed [WIDTH-1:0]     w_row [SHARED_DIM];
  logic signed [WIDTH-1:0]     e_elem;
  logic signed [ACC_WIDTH-1:0] acc   [SHARED_DIM];
  logic                        lane_clr;
  logic                        lane_en;

  function automatic logic signed [ACC_WIDTH-1:0] out_fn(input logic signed [ACC_WIDTH-1:0] v);
`ifdef MVM_TRANSPOSE_SAT_EN
    return ACC_WIDTH'(saturate(64'(v), WIDTH));
`else
    return v;
`endif
  endfunction

  // Select the current row of W and element of e. A compare-per-row mux keeps
  // every part-select constant, so row_idx values past the last row are safe.
  always_comb begin
    e_elem = '0;
    for (int c = 0; c < SHARED_DIM; c++) w_row[c] = '0;
    for (int r = 0; r < MATRIX_ROWS; r++) begin
      if (row_idx_q == RIDX_W'(r)) begin
        e_elem = vector_q[WIDTH*(MATRIX_ROWS-r)-1 -: WIDTH];
        for (int c = 0; c < SHARED_DIM; c++)
          w_row[c] = matrix_q[WIDTH*SHARED_DIM*(MATRIX_ROWS-r) - WIDTH*c - 1 -: WIDTH];
      end
    end
  end

  // Accumulators are cleared on the same edge that captures the operands.
  assign lane_clr = (state_q == S_IDLE) && start;
  assign lane_en  = (state_q == S_ACCUM);

  for (genvar c = 0; c < SHARED_DIM; c++) begin : g_lane
    mac_lane #(
      .WIDTH     (WIDTH),
      .ACC_WIDTH (ACC_WIDTH)
    ) u_mac (
      .clk   (clk),
      .reset (reset),
      .clr_i (lane_clr),
      .en_i  (lane_en),
      .a_i   (w_row[c]),
      .b_i   (e_elem),
      .acc_o (acc[c])
    );
  end

  // busy is registered so it stays high through the done cycle (state is
  // already back in IDLE then) and stays high across a back-to-back restart.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      row_idx_q <= '0;
      matrix_q  <= '0;
      vector_q  <= '0;
      result_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          busy_q <= start;
          if (start) begin
            matrix_q  <= matrix;
            vector_q  <= vector;
            row_idx_q <= '0;
            state_q   <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          busy_q <= 1'b1;
          done_q <= 1'b0;
          if (row_idx_q == LAST_ROW) state_q   <= S_DONE;
          else                       row_idx_q <= row_idx_q + RIDX_W'(1);
        end
        S_DONE: begin
          for (int c = 0; c < SHARED_DIM; c++)
            result_q[ACC_WIDTH*(SHARED_DIM-c)-1 -: ACC_WIDTH] <= out_fn(acc[c]);
          busy_q  <= 1'b1;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign result_vector = result_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_mvm_transpose.sv
// -----------------------------------------------------------------------------
// tb_mvm_transpose
// Directed and randomized bench for mvm_transpose. Expected results come from
// a plain-arithmetic dot-product model over the bench's own W/e arrays.
// Honors MVM_TRANSPOSE_SAT_EN for the expected output clamp.
// -----------------------------------------------------------------------------
module tb_mvm_transpose;

  localparam int MR = 6;
  localparam int SD = 3;
  localparam int WD = 8;
  localparam int AW = 19;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic [MR*SD*WD-1:0]  matrix;
  logic [MR*WD-1:0]     vector;
  logic [SD*AW-1:0]     result_vector;
  logic                 busy;
  logic                 done;

  int W [MR][SD];
  int E [MR];
  int n_vec  = 0;
  int n_fail = 0;

  mvm_transpose #(
    .MATRIX_ROWS (MR),
    .SHARED_DIM  (SD),
    .WIDTH       (WD),
    .ACC_WIDTH   (AW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .matrix        (matrix),
    .vector        (vector),
    .result_vector (result_vector),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [63:0] y_dut(input int c);
    logic signed [AW-1:0] s;
    s = result_vector[AW*(SD-c)-1 -: AW];
    return 64'(s);
  endfunction

  function automatic logic signed [63:0] y_ref(input int c);
    longint s;
    s = 0;
    for (int r = 0; r < MR; r++) s += longint'(W[r][c]) * longint'(E[r]);
`ifdef MVM_TRANSPOSE_SAT_EN
    if (s > 127)  s = 127;
    if (s < -128) s = -128;
`endif
    return 64'(s);
  endfunction

  task automatic apply_ops();
    for (int r = 0; r < MR; r++) begin
      vector[WD*(MR-r)-1 -: WD] = WD'(E[r]);
      for (int c = 0; c < SD; c++)
        matrix[WD*SD*(MR-r) - WD*c - 1 -: WD] = WD'(W[r][c]);
    end
  endtask

  task automatic set_case1();
    for (int r = 0; r < MR; r++) begin
      E[r] = r + 1;
      for (int c = 0; c < SD; c++) W[r][c] = 1;
    end
  endtask

  task automatic set_case2();
    for (int r = 0; r < MR; r++) begin
      E[r] = 2;
      W[r][0] = r + 1;
      W[r][1] = -(r + 1);
      W[r][2] = 0;
    end
  endtask

  task automatic set_case3();
    for (int r = 0; r < MR; r++) begin
      E[r] = -128;
      for (int c = 0; c < SD; c++) W[r][c] = -128;
    end
  endtask

  task automatic set_random();
    for (int r = 0; r < MR; r++) begin
      E[r] = int'($urandom_range(255)) - 128;
      for (int c = 0; c < SD; c++) W[r][c] = int'($urandom_range(255)) - 128;
    end
  endtask

  task automatic check_result(input string tag);
    for (int c = 0; c < SD; c++)
      chk($sformatf("%s_y%0d", tag, c), y_dut(c), y_ref(c));
  endtask

  task automatic start_pulse();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts cycles until done is seen; busy must hold high while waiting.
  task automatic wait_done(input string tag, output int n);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      chk({tag, "_busy_run"}, 64'(busy), 64'sd1);
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, 64'(done), 64'sd1);
    chk({tag, "_busy_at_done"}, 64'(busy), 64'sd1);
  endtask

  task automatic run_case(input string tag);
    int n;
    apply_ops();
    start_pulse();
    wait_done(tag, n);
    chk({tag, "_latency"}, 64'(n), 64'sd7);
    check_result(tag);
    @(negedge clk);
    chk({tag, "_done_drop"}, 64'(done), 64'sd0);
    chk({tag, "_busy_drop"}, 64'(busy), 64'sd0);
  endtask

  initial begin
    int n;
    int pulses;
    reset  = 1'b1;
    start  = 1'b0;
    matrix = '0;
    vector = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'sd0);
    chk("rst_done", 64'(done), 64'sd0);
    chk("rst_result", 64'(result_vector), 64'sd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'sd0);

    set_case1(); run_case("c1");
    set_case2(); run_case("c2");
    set_case3(); run_case("c3");

    // Operands change and start re-pulses one cycle into the run.
    set_case1();
    apply_ops();
    start_pulse();
    matrix = '0;
    vector = '0;
    start_pulse();
    wait_done("c4", n);
    chk("c4_latency", 64'(n), 64'sd6);
    check_result("c4");
    @(negedge clk);
    pulses = 0;
    repeat (12) begin
      if (done === 1'b1) pulses++;
      @(negedge clk);
    end
    chk("c4_extra_done", 64'(pulses), 64'sd0);
    chk("c4_busy_idle", 64'(busy), 64'sd0);

    // Reset during the third ACCUM cycle.
    set_case1();
    apply_ops();
    start_pulse();
    repeat (2) @(negedge clk);
    chk("c5_busy_pre", 64'(busy), 64'sd1);
    reset = 1'b1;
    #1;
    chk("c5_busy_rst", 64'(busy), 64'sd0);
    chk("c5_done_rst", 64'(done), 64'sd0);
    chk("c5_result_rst", 64'(result_vector), 64'sd0);
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    repeat (12) begin
      if (done === 1'b1) pulses++;
      @(negedge clk);
    end
    chk("c5_no_done", 64'(pulses), 64'sd0);
    chk("c5_busy_after", 64'(busy), 64'sd0);
    chk("c5_result_after", 64'(result_vector), 64'sd0);
    set_case2(); run_case("c5b");

    // Back-to-back: new start in the done cycle.
    set_case1();
    apply_ops();
    start_pulse();
    wait_done("c6a", n);
    chk("c6a_latency", 64'(n), 64'sd7);
    check_result("c6a");
    set_case2();
    apply_ops();
    start_pulse();
    wait_done("c6b", n);
    chk("c6b_latency", 64'(n), 64'sd7);
    check_result("c6b");
    @(negedge clk);
    chk("c6b_done_drop", 64'(done), 64'sd0);

    for (int i = 0; i < 10; i++) begin
      set_random();
      run_case($sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
